// File: rtl/circ_conv_sample_buffer.sv
// Ping-pong (x, h) sample buffer feeding the circular convolution core.
// One bank loads a frame while the other serves x[k] and h[(n-k) mod N].
module circ_conv_sample_buffer #(
  parameter int N_LOG2 = 3,
  parameter int DW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_x,
  input  logic [DW-1:0]     in_h,
  output logic              frame_ready,
  input  logic              frame_release,
  input  logic [N_LOG2-1:0] rd_n,
  input  logic [N_LOG2-1:0] rd_k,
  output logic [DW-1:0]     rd_x,
  output logic [DW-1:0]     rd_h,
  output logic              rd_valid,
  output logic [7:0]        frames_loaded
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  logic [DW-1:0]     x_mem [2][N];
  logic [DW-1:0]     h_mem [2][N];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [N_LOG2-1:0] wr_idx;
  logic [N_LOG2-1:0] h_idx;
  logic              xfer;
  logic              last;
  logic              rel;

  assign in_ready    = !full[wr_bank];
  assign frame_ready = full[rd_bank];
  assign xfer        = in_valid && in_ready;
  assign last        = xfer && (wr_idx == LAST);
  assign rel         = frame_release && frame_ready;
  // Wrap of the N_LOG2-bit difference is the mod N
  assign h_idx       = rd_n - rd_k;

  always_ff @(posedge clk) begin
    if (xfer) begin
      x_mem[wr_bank][wr_idx] <= in_x;
      h_mem[wr_bank][wr_idx] <= in_h;
    end
  end

  // Completing and releasing banks never coincide on the same bank
  always_ff @(posedge clk) begin
    if (reset) begin
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      frames_loaded <= '0;
      rd_x          <= '0;
      rd_h          <= '0;
      rd_valid      <= 1'b0;
    end else begin
      if (xfer) begin
        wr_idx <= last ? '0 : wr_idx + 1'b1;
      end
      if (last) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        frames_loaded <= frames_loaded + 8'd1;
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      rd_valid <= frame_ready;
      if (frame_ready) begin
        rd_x <= x_mem[rd_bank][rd_k];
        rd_h <= h_mem[rd_bank][h_idx];
      end else begin
        rd_x <= '0;
        rd_h <= '0;
      end
    end
  end

endmodule

// File: tb/tb_circ_conv_sample_buffer.sv
// Bench for circ_conv_sample_buffer: directed tables, corner sequences
// and random traffic against a frame-queue reference model.
module tb_circ_conv_sample_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_x = '0;
  logic [2:0] in_h = '0;
  logic       frame_ready;
  logic       frame_release = 1'b0;
  logic [2:0] rd_n = '0;
  logic [2:0] rd_k = '0;
  logic [2:0] rd_x;
  logic [2:0] rd_h;
  logic       rd_valid;
  logic [7:0] frames_loaded;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  circ_conv_sample_buffer #(.N_LOG2(3), .DW(3)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_h(in_h),
    .frame_ready(frame_ready),
    .frame_release(frame_release),
    .rd_n(rd_n),
    .rd_k(rd_k),
    .rd_x(rd_x),
    .rd_h(rd_h),
    .rd_valid(rd_valid),
    .frames_loaded(frames_loaded)
  );

  // Reference: a queue of completed frames (oldest is the one being read)
  typedef struct packed {
    logic [7:0][2:0] x;
    logic [7:0][2:0] h;
  } frame_t;

  frame_t     fq[$];
  frame_t     cur;
  int         cur_n = 0;
  logic [7:0] m_loaded = '0;
  logic [2:0] m_rdx = '0;
  logic [2:0] m_rdh = '0;
  logic       m_rdv = 1'b0;

  typedef struct {
    int n;
    int k;
    int x;
    int h;
  } vec_t;

  vec_t vt[65];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] idx;
    logic       mx;
    logic       mr;
    if (reset) begin
      fq.delete();
      cur_n    = 0;
      m_loaded = '0;
      m_rdx    = '0;
      m_rdh    = '0;
      m_rdv    = 1'b0;
    end else begin
      idx = rd_n - rd_k;
      if (fq.size() > 0) begin
        m_rdx = fq[0].x[rd_k];
        m_rdh = fq[0].h[idx];
        m_rdv = 1'b1;
      end else begin
        m_rdx = '0;
        m_rdh = '0;
        m_rdv = 1'b0;
      end
      mx = in_valid && (fq.size() < 2);
      mr = frame_release && (fq.size() > 0);
      if (mr) void'(fq.pop_front());
      if (mx) begin
        cur.x[cur_n] = in_x;
        cur.h[cur_n] = in_h;
        cur_n++;
        if (cur_n == 8) begin
          fq.push_back(cur);
          cur_n = 0;
          m_loaded = m_loaded + 8'd1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready", int'(in_ready), int'(fq.size() < 2));
    chk("frame_ready", int'(frame_ready), int'(fq.size() > 0));
    chk("rd_x", int'(rd_x), int'(m_rdx));
    chk("rd_h", int'(rd_h), int'(m_rdh));
    chk("rd_valid", int'(rd_valid), int'(m_rdv));
    chk("frames_loaded", int'(frames_loaded), int'(m_loaded));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    frame_release = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int x, input int h);
    in_valid = 1'b1;
    in_x = 3'(x);
    in_h = 3'(h);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_frame_ready"}, int'(frame_ready), 0);
    chk({tag, "_rd_x"}, int'(rd_x), 0);
    chk({tag, "_rd_h"}, int'(rd_h), 0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_loaded"}, int'(frames_loaded), 0);
  endtask

  initial begin
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) begin
        vt[n*8+k] = '{n, k, k, 7 - ((n - k) & 7)};
      end
    end
    vt[64] = '{1, 3, 3, 1};

    // Reset, then one continuous frame x=0..7, h=7..0
    do_reset();
    check_reset_vals("rst");
    for (int i = 0; i < 8; i++) begin
      chk("ld_in_ready", int'(in_ready), 1);
      chk("ld_fr_low", int'(frame_ready), 0);
      push(i, 7 - i);
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    chk("ld_frame_ready", int'(frame_ready), 1);
    chk("ld_loaded", int'(frames_loaded), 1);

    // Table sweep of (n, k); result lands one cycle later
    for (int i = 0; i < 65; i++) begin
      rd_n = 3'(vt[i].n);
      rd_k = 3'(vt[i].k);
      tick();
      chk("sweep_x", int'(rd_x), vt[i].x);
      chk("sweep_h", int'(rd_h), vt[i].h);
      chk("sweep_v", int'(rd_valid), 1);
    end

    // Fill both banks, stall the 17th pair, release one bank
    do_reset();
    for (int i = 0; i < 16; i++) push($urandom, $urandom);
    chk("both_full_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    in_x = 3'd5;
    in_h = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", int'(in_ready), 0);
    end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    chk("rel_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    for (int i = 0; i < 7; i++) push($urandom, $urandom);
    rd_n = 3'd0;
    rd_k = 3'd0;
    tick();
    chk("p17_x", int'(rd_x), 5);
    chk("p17_h", int'(rd_h), 2);

    // Release coinciding with completion of the second frame
    do_reset();
    for (int i = 0; i < 8; i++) push(i, i);
    for (int i = 0; i < 7; i++) push(7 - i, 3);
    frame_release = 1'b1;
    push(0, 6);
    frame_release = 1'b0;
    chk("sim_frame_ready", int'(frame_ready), 1);
    chk("sim_loaded", int'(frames_loaded), 2);
    for (int i = 0; i < 8; i++) begin
      rd_n = 3'(i);
      rd_k = 3'(i);
      tick();
      chk("sim_x", int'(rd_x), (i == 7) ? 0 : 7 - i);
      chk("sim_h0", int'(rd_h), 3);
    end

    // Release while nothing is ready is ignored
    do_reset();
    frame_release = 1'b1;
    tick();
    tick();
    frame_release = 1'b0;
    chk("idle_rel_fr", int'(frame_ready), 0);
    chk("idle_rel_ir", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) push(i ^ 5, i);
    chk("idle_rel_bank", int'(frame_ready), 1);
    rd_k = 3'd2;
    rd_n = 3'd2;
    tick();
    chk("idle_rel_x", int'(rd_x), 7);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 8; i++) push(1, 1);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    for (int i = 0; i < 5; i++) push(6, 6);
    do_reset();
    check_reset_vals("mid");
    for (int i = 0; i < 8; i++) push(7 - i, i ^ 2);
    chk("mid_frame_ready", int'(frame_ready), 1);
    chk("mid_loaded", int'(frames_loaded), 1);
    for (int i = 0; i < 8; i++) begin
      rd_n = 3'd0;
      rd_k = 3'(i);
      tick();
      chk("mid_x", int'(rd_x), 7 - i);
    end

    // Random traffic against the frame-queue model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_x = 3'($urandom);
      in_h = 3'($urandom);
      frame_release = ($urandom_range(0, 7) == 0);
      rd_n = 3'($urandom);
      rd_k = 3'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    frame_release = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
